alu_result_select_pipe: RTL and testbench
=========================================

// Module: alu_result_select_pipe
// PURPOSE
//   Parametrised, registered successor of the combinational ALU result mux.
//   Picks one of NUM_OPS unit results by opcode, computes S/Z, selects the
//   matching C/V, and flags unimplemented opcodes.
//   Buffers up to 2 results in an output queue with valid/ready handshakes.
//   Sits between the ALU units and register-file writeback.
// PARAMETERS
//   WIDTH       16          datapath width in bits
//   OPW         4           opcode width; NUM_OPS = 2**OPW
//   IMPL_MASK   16'h0F7F    bit k set = opcode k implemented (default: 0-6, 8-11)
//   DEFAULT_VAL {WIDTH{1}}  result driven for unimplemented opcodes
// PORTS
//   clk          in   1              clock, all state on rising edge
//   rst          in   1              synchronous reset, active-high
//   in_valid     in   1              input beat present
//   in_ready     out  1              block can accept a beat
//   opcode       in   OPW            operation select
//   results      in   NUM_OPS*WIDTH  packed unit results; op k at [k*WIDTH +: WIDTH]
//   carry_vec    in   NUM_OPS        per-op carry-out
//   ovf_vec      in   NUM_OPS        per-op signed overflow
//   out_valid    out  1              output beat present
//   out_ready    in   1              consumer accepts beat
//   out_data     out  WIDTH          selected result
//   out_flags    out  4              {S,Z,C,V}
//   out_illegal  out  1              opcode was unimplemented
//   illegal_cnt  out  16             count of accepted illegal beats (see CONFIGURATION)
// BEHAVIOUR
//   - Push = in_valid & in_ready; pop = out_valid & out_ready.
//   - Reset (sync, dominates all): queue empty, out_valid=0, out_data=0, out_flags=0,
//     out_illegal=0, illegal_cnt=0. in_ready=1 in the first cycle after reset.
//   - Select: legal = IMPL_MASK[opcode]. If legal: data=results[opcode], C=carry_vec[opcode],
//     V=ovf_vec[opcode]. Else: data=DEFAULT_VAL, C=0, V=0, illegal=1.
//   - Flags come from the selected data: S=data[WIDTH-1], Z=(data==0).
//     They are computed on DEFAULT_VAL for illegal ops (S=1, Z=0 at default).
//   - Queue: 2-entry FIFO of {data,flags,illegal}; count in {0,1,2}.
//   - in_ready = (count!=2). Registered from state only; no combinational path
//     from out_ready.
//   - out_valid = (count!=0). Head entry drives out_data/out_flags/out_illegal.
//     The head is held stable while out_valid & !out_ready.
//   - Latency: a beat pushed in cycle N is visible at the head in cycle N+1 if
//     the queue was empty or popped in cycle N.
//   - Simultaneous push+pop at count=1: count stays 1, the new beat becomes head
//     next cycle; full throughput 1 beat/cycle.
//   - count=2: in_ready=0; pop alone -> count=1, second entry becomes head.
//   - count=0: pop impossible (out_valid=0); out_ready is ignored.
//   - Reset mid-operation discards all queued beats; no partial output.
//   - Inputs sampled only on push; opcode/results are don't-care otherwise.
// CONFIGURATION
//   ALU_ILLEGAL_CNT_EN defined:
//     illegal_cnt increments on each push with illegal=1 and saturates at 16'hFFFF.
//     It is cleared only by rst.
//   Not defined:
//     No counter logic; illegal_cnt is tied to 16'h0000. All other behaviour is identical.
// TESTING
//   1. rst=1 for 2 cycles -> out_valid=0, out_data=0, out_flags=0, in_ready=1, illegal_cnt=0.
//   2. opcode=0, results[op0]=16'h0000, carry_vec[0]=1, push, out_ready=1 ->
//      next cycle out_data=16'h0000, out_flags=4'b0110, out_illegal=0.
//   3. opcode=7 (unimplemented), push -> out_data=16'hFFFF, flags=4'b1000, out_illegal=1;
//      with ALU_ILLEGAL_CNT_EN, illegal_cnt=1; without it, illegal_cnt=0.
//   4. out_ready=0, push 3 beats (op1=16'h8001, op2=16'h0002, op3=16'h0003) ->
//      in_ready=0 after the 2nd beat, 3rd beat stalls.
//      Raise out_ready -> outputs 16'h8001, 16'h0002, 16'h0003 in order, none lost.
//   5. Continuous push with out_ready=1 for 8 cycles ->
//      one beat per cycle, in_ready held 1, results in order.
//   6. count=2, assert rst for 1 cycle -> out_valid=0 next cycle, in_ready=1;
//      discarded beats never appear at the output.

Source files
------------

// File: rtl/alu_result_select_pipe.sv
// Registered ALU result select: picks one unit result by opcode, derives {S,Z,C,V},
// flags unimplemented opcodes and buffers beats in a 2-entry output queue.
// Optional illegal-beat counter is enabled by defining ALU_ILLEGAL_CNT_EN.
module alu_result_select_pipe #(
  parameter int                  WIDTH       = 16,
  parameter int                  OPW         = 4,
  parameter logic [2**OPW-1:0]   IMPL_MASK   = 16'h0F7F,
  parameter logic [WIDTH-1:0]    DEFAULT_VAL = {WIDTH{1'b1}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPW-1:0]            opcode,
  input  logic [(2**OPW)*WIDTH-1:0] results,
  input  logic [2**OPW-1:0]         carry_vec,
  input  logic [2**OPW-1:0]         ovf_vec,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [3:0]                out_flags,
  output logic                      out_illegal,
  output logic [15:0]               illegal_cnt
);

  function automatic logic [3:0] make_flags(input logic signed [WIDTH-1:0] d,
                                            input logic c, input logic v);
    return {(d < 0), (d == '0), c, v};
  endfunction

  logic                    push, pop;
  logic [1:0]              count;

  // Stage p0: combinational operand select and flag generation
  logic                    sel_legal_p0;
  logic signed [WIDTH-1:0] sel_data_p0;
  logic                    sel_c_p0, sel_v_p0;
  logic [3:0]              sel_flags_p0;

  always_comb begin
    sel_legal_p0 = IMPL_MASK[opcode];
    sel_data_p0  = DEFAULT_VAL;
    sel_c_p0     = 1'b0;
    sel_v_p0     = 1'b0;
    if (sel_legal_p0) begin
      sel_data_p0 = results[int'(opcode)*WIDTH +: WIDTH];
      sel_c_p0    = carry_vec[opcode];
      sel_v_p0    = ovf_vec[opcode];
    end
    sel_flags_p0 = make_flags(sel_data_p0, sel_c_p0, sel_v_p0);
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Stage p1: queue head (drives outputs) and tail entry
  logic signed [WIDTH-1:0] head_data_p1, tail_data_p1;
  logic [3:0]              head_flags_p1, tail_flags_p1;
  logic                    head_ill_p1, tail_ill_p1;
  logic                    vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= 2'd0;
      head_data_p1  <= '0;
      head_flags_p1 <= 4'd0;
      head_ill_p1   <= 1'b0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop && count == 2'd2) begin
        head_data_p1  <= tail_data_p1;
        head_flags_p1 <= tail_flags_p1;
        head_ill_p1   <= tail_ill_p1;
      end else if (push && (count == 2'd0 || pop)) begin
        head_data_p1  <= sel_data_p0;
        head_flags_p1 <= sel_flags_p0;
        head_ill_p1   <= ~sel_legal_p0;
      end
    end
  end

  // Tail only ever holds the second queued beat, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push && count == 2'd1 && !pop) begin
      tail_data_p1  <= sel_data_p0;
      tail_flags_p1 <= sel_flags_p0;
      tail_ill_p1   <= ~sel_legal_p0;
    end
  end

  assign vld_p1      = (count != 2'd0);
  assign out_valid   = vld_p1;
  assign in_ready    = (count != 2'd2);
  assign out_data    = head_data_p1;
  assign out_flags   = head_flags_p1;
  assign out_illegal = head_ill_p1;

`ifdef ALU_ILLEGAL_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  logic [15:0] ill_cnt_p1;

  always_ff @(posedge clk) begin
    if (rst)
      ill_cnt_p1 <= 16'd0;
    else if (push && !sel_legal_p0)
      ill_cnt_p1 <= sat_inc(ill_cnt_p1);
  end

  assign illegal_cnt = ill_cnt_p1;
`else
  assign illegal_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_result_select_pipe.sv
// Scoreboard bench for alu_result_select_pipe: beats are modelled when pushed
// and compared in order when popped, with per-scenario directed checks.
module tb_alu_result_select_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = 4'd0;
  logic [255:0] results = '0;
  logic [15:0]  carry_vec = '0;
  logic [15:0]  ovf_vec = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [15:0]  out_data;
  logic [3:0]   out_flags;
  logic         out_illegal;
  logic [15:0]  illegal_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  flags;
    logic        ill;
  } beat_t;

  beat_t       sb[$];
  beat_t       mon_b;
  logic [15:0] exp_cnt = 16'd0;

  alu_result_select_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .results(results), .carry_vec(carry_vec), .ovf_vec(ovf_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  function automatic beat_t model(input logic [3:0] op, input logic [255:0] res,
                                  input logic [15:0] cv, input logic [15:0] ov);
    beat_t       b;
    logic [15:0] mask;
    mask = 16'h0F7F;
    if (mask[op]) begin
      b.data     = res[int'(op)*16 +: 16];
      b.flags[1] = cv[op];
      b.flags[0] = ov[op];
      b.ill      = 1'b0;
    end else begin
      b.data       = 16'hFFFF;
      b.flags[1:0] = 2'b00;
      b.ill        = 1'b1;
    end
    b.flags[3] = b.data[15];
    b.flags[2] = (b.data == 16'h0000);
    return b;
  endfunction

  // Monitor on the falling edge: handshakes seen here are what the next rising edge samples.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_cnt = 16'd0;
    end else begin
      checks++;
      if (out_valid !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL sb_out_valid: got %b want %b", out_valid, (sb.size() != 0));
      end
      checks++;
      if (in_ready !== (sb.size() < 2)) begin
        errors++;
        $display("FAIL sb_in_ready: got %b want %b", in_ready, (sb.size() < 2));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got pop with data %h want no output", out_data);
        end else begin
          mon_b = sb.pop_front();
          if ({out_data, out_flags, out_illegal} !== mon_b) begin
            errors++;
            $display("FAIL sb_beat: got data=%h flags=%b ill=%b want data=%h flags=%b ill=%b",
                     out_data, out_flags, out_illegal, mon_b.data, mon_b.flags, mon_b.ill);
          end
        end
      end
      if (in_valid && in_ready) begin
        mon_b = model(opcode, results, carry_vec, ovf_vec);
        sb.push_back(mon_b);
        if (mon_b.ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [3:0] op, input logic [15:0] val,
                          input logic c, input logic v);
    for (int k = 0; k < 16; k++) results[k*16 +: 16] = 16'($urandom);
    results[int'(op)*16 +: 16] = val;
    carry_vec     = 16'($urandom);
    carry_vec[op] = c;
    ovf_vec       = 16'($urandom);
    ovf_vec[op]   = v;
    opcode        = op;
    in_valid      = 1'b1;
  endtask

  function automatic logic [15:0] cnt_want(input logic [15:0] n);
`ifdef ALU_ILLEGAL_CNT_EN
    return n;
`else
    return 16'h0000 & n;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    checks++; if (out_flags !== 4'b0000) begin errors++; $display("FAIL rst_out_flags: got %b want 0000", out_flags); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL rst_out_illegal: got %b want 0", out_illegal); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (illegal_cnt !== 16'h0000) begin errors++; $display("FAIL rst_illegal_cnt: got %h want 0000", illegal_cnt); end
  endtask

  task automatic test_select();
    out_ready = 1'b1;
    set_beat(4'd0, 16'h0000, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sel0_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL sel0_data: got %h want 0000", out_data); end
    checks++; if (out_flags !== 4'b0110) begin errors++; $display("FAIL sel0_flags: got %b want 0110", out_flags); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL sel0_illegal: got %b want 0", out_illegal); end
    set_beat(4'd5, 16'h8000, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== 16'h8000) begin errors++; $display("FAIL sel5_data: got %h want 8000", out_data); end
    checks++; if (out_flags !== 4'b1001) begin errors++; $display("FAIL sel5_flags: got %b want 1001", out_flags); end
    set_beat(4'd8, 16'h1234, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL sel8_data: got %h want 1234", out_data); end
    checks++; if (out_flags !== 4'b0011) begin errors++; $display("FAIL sel8_flags: got %b want 0011", out_flags); end
    tick();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    set_beat(4'd7, 16'h5555, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== 16'hFFFF) begin errors++; $display("FAIL ill7_data: got %h want FFFF", out_data); end
    checks++; if (out_flags !== 4'b1000) begin errors++; $display("FAIL ill7_flags: got %b want 1000", out_flags); end
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL ill7_illegal: got %b want 1", out_illegal); end
    checks++; if (illegal_cnt !== cnt_want(16'd1)) begin errors++; $display("FAIL ill7_cnt: got %h want %h", illegal_cnt, cnt_want(16'd1)); end
    set_beat(4'd15, 16'h0000, 1'b1, 1'b0);
    tick();
    set_beat(4'd11, 16'h0042, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL ill11_illegal: got %b want 0", out_illegal); end
    checks++; if (illegal_cnt !== cnt_want(16'd2)) begin errors++; $display("FAIL ill_cnt2: got %h want %h", illegal_cnt, cnt_want(16'd2)); end
    checks++; if (illegal_cnt !== cnt_want(exp_cnt)) begin errors++; $display("FAIL ill_cnt_model: got %h want %h", illegal_cnt, cnt_want(exp_cnt)); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_beat(4'd1, 16'h8001, 1'b0, 1'b0);
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
    set_beat(4'd2, 16'h0002, 1'b0, 1'b0);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready2: got %b want 0", in_ready); end
    set_beat(4'd3, 16'h0003, 1'b0, 1'b0);
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b want 0", in_ready); end
    checks++; if (out_data !== 16'h8001) begin errors++; $display("FAIL bp_hold: got %h want 8001", out_data); end
    checks++; if (out_flags !== 4'b1000) begin errors++; $display("FAIL bp_hold_flags: got %b want 1000", out_flags); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 16'h0002) begin errors++; $display("FAIL bp_second: got %h want 0002", out_data); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== 16'h0003) begin errors++; $display("FAIL bp_third: got %h want 0003", out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_beat(4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom), 1'($urandom));
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    set_beat(4'd4, 16'h1111, 1'b0, 1'b0);
    tick();
    set_beat(4'd12, 16'h2222, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full: got %b want 0", in_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", in_ready); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL flush_data: got %h want 0000", out_data); end
    checks++; if (illegal_cnt !== 16'h0000) begin errors++; $display("FAIL flush_cnt: got %h want 0000", illegal_cnt); end
    out_ready = 1'b1;
    set_beat(4'd9, 16'h3333, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== 16'h3333) begin errors++; $display("FAIL flush_next: got %h want 3333", out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_end: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_select();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_flush();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d beats want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
